// File: rtl/ser_pkg.sv
// Shared types and the parameter sanity helper for the FIFO word serializer.
package ser_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ser_state_e;

  // Returns IN/OUT when OUT divides IN exactly, else 0.
  function automatic int unsigned ser_ratio(int unsigned in_w, int unsigned out_w);
    if (out_w == 0) return 0;
    if ((in_w % out_w) != 0) return 0;
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops wide words from an upstream valid/grant FIFO and emits them as RATIO narrow chunks,
// flagging the final chunk of each word with last_o.
module fifo_word_serializer
  import ser_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic [IN_WIDTH-1:0]  data_i,
  input  logic                 valid_i,
  output logic                 grant_o,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic                 last_o,
  input  logic                 grant_i
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(RATIO - 1);
  localparam logic [CNT_W:0] GrantMax = (CNT_W + 1)'(RATIO);

  if (ser_ratio(IN_WIDTH, OUT_WIDTH) < 2) begin : gen_bad_ratio
    $error("fifo_word_serializer: IN_WIDTH must be a multiple (>= 2x) of OUT_WIDTH");
  end

  ser_state_e                     state_q, state_d;
  logic [IN_WIDTH-1:0]            word_q, word_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CNT_W-1:0]               sel;
  logic [RATIO-1:0][OUT_WIDTH-1:0] chunks;
  logic                           is_last;
  logic                           xfer;
  logic                           accept;

  assign chunks  = word_q;
  assign sel     = MSB_FIRST ? (CntLast - cnt_q) : cnt_q;
  assign is_last = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    grant_o = 1'b0;
    valid_o = 1'b0;
    data_o  = '0;
    last_o  = 1'b0;

    unique case (state_q)
      IDLE: grant_o = 1'b1;
      BUSY: begin
        valid_o = 1'b1;
        data_o  = chunks[sel];
        last_o  = is_last;
        // Pop the next word in the same cycle the last chunk leaves: no bubble.
        grant_o = grant_i && is_last;
      end
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      grant_o = 1'b0;
      valid_o = 1'b0;
    end

    xfer   = valid_o && grant_i;
    accept = valid_i && grant_o;

    if (xfer) begin
      if (is_last) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (accept) begin
      word_d  = data_i;
      cnt_d   = '0;
      state_d = BUSY;
    end

    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Chunks granted for the word currently held; only observed by the assertions below.
  logic [CNT_W:0] grants_q, grants_d;

  always_comb begin
    grants_d = grants_q;
    if (xfer) grants_d = grants_q + (CNT_W + 1)'(1);
    if (accept || clear_i) grants_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants_q <= '0;
    end else begin
      grants_q <= grants_d;
    end
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_o && !grant_i) |=> ($stable(data_o) && $stable(last_o)));

  a_grant_bound: assert property (@(posedge clk) disable iff (!rst_n)
    xfer |-> (grants_q < GrantMax));

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: a small registered FIFO model feeds an LSB-first and an MSB-first serializer.
module tb_fifo_word_serializer;

  logic        clk;
  logic        rst_n;
  logic        clear_i;
  logic        grant_i;
  logic        push;
  logic [31:0] push_data;

  logic [31:0] data_i;
  logic        valid_i;
  logic        grant_o0, grant_o1;
  logic [7:0]  data_o0, data_o1;
  logic        valid_o0, valid_o1;
  logic        last_o0, last_o1;

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO model: valid/data come from registered state only.
  logic [31:0] mem [16];
  int          wr_ptr, rd_ptr, fcnt, pops;

  assign valid_i = (fcnt != 0);
  assign data_i  = mem[rd_ptr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 0;
      rd_ptr <= 0;
      fcnt   <= 0;
      pops   <= 0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr + 1) % 16;
      end
      if (valid_i && grant_o0) begin
        rd_ptr <= (rd_ptr + 1) % 16;
        pops   <= pops + 1;
      end
      fcnt <= fcnt + (push ? 1 : 0) - ((valid_i && grant_o0) ? 1 : 0);
    end
  end

  fifo_word_serializer #(
    .IN_WIDTH (32),
    .OUT_WIDTH(8),
    .MSB_FIRST(1'b0)
  ) u_dut_lsb (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(clear_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .grant_o(grant_o0),
    .data_o (data_o0),
    .valid_o(valid_o0),
    .last_o (last_o0),
    .grant_i(grant_i)
  );

  fifo_word_serializer #(
    .IN_WIDTH (32),
    .OUT_WIDTH(8),
    .MSB_FIRST(1'b1)
  ) u_dut_msb (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(clear_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .grant_o(grant_o1),
    .data_o (data_o1),
    .valid_o(valid_o1),
    .last_o (last_o1),
    .grant_i(grant_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic [7:0] d, input logic v, input logic l,
                         input logic g);
    check_eq({tag, "_data"},  32'(data_o0),  32'(d));
    check_eq({tag, "_valid"}, 32'(valid_o0), 32'(v));
    check_eq({tag, "_last"},  32'(last_o0),  32'(l));
    check_eq({tag, "_grant"}, 32'(grant_o0), 32'(g));
  endtask

  // Advance one cycle; returns in the low phase, where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    push      = 1'b1;
    push_data = w;
    tick();
    push      = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] w2;
    int          p0;

    rst_n     = 1'b0;
    clear_i   = 1'b0;
    grant_i   = 1'b1;
    push      = 1'b0;
    push_data = '0;
    #1;
    exp_out("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single word, free-flowing consumer.
    w  = 32'hDDCCBBAA;
    p0 = pops;
    push_word(w);
    #1;
    exp_out("t1_idle", 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_out($sformatf("t1_c%0d", i), 8'(w >> (8 * i)), 1'b1, i == 3, i == 3);
      tick();
    end
    #1;
    exp_out("t1_done", 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("t1_pops", 32'(pops - p0), 32'd1);

    // Two words back-to-back: no bubble between chunk 04 and 05.
    push      = 1'b1;
    push_data = 32'h04030201;
    tick();
    push_data = 32'h08070605;
    #1;
    exp_out("t2_idle", 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    push = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_out($sformatf("t2_c%0d", i), 8'(i + 1), 1'b1, (i % 4) == 3, (i % 4) == 3);
      tick();
    end
    #1;
    exp_out("t2_done", 8'h00, 1'b0, 1'b0, 1'b1);

    // Backpressure on chunk BB for three cycles.
    w = 32'hDDCCBBAA;
    push_word(w);
    tick();
    #1;
    exp_out("t3_c0", 8'hAA, 1'b1, 1'b0, 1'b0);
    tick();
    grant_i = 1'b0;
    p0      = pops;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_out($sformatf("t3_stall%0d", i), 8'hBB, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_eq("t3_stall_pops", 32'(pops - p0), 32'd0);
    grant_i = 1'b1;
    #1;
    exp_out("t3_c1", 8'hBB, 1'b1, 1'b0, 1'b0);
    tick();
    #1;
    exp_out("t3_c2", 8'hCC, 1'b1, 1'b0, 1'b0);
    tick();
    #1;
    exp_out("t3_c3", 8'hDD, 1'b1, 1'b1, 1'b1);
    tick();
    #1;
    exp_out("t3_done", 8'h00, 1'b0, 1'b0, 1'b1);

    // MSB-first order on the second instance.
    w = 32'h11223344;
    push_word(w);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("t4_msb_data%0d", i), 32'(data_o1), 32'(8'(w >> (8 * (3 - i)))));
      check_eq($sformatf("t4_msb_last%0d", i), 32'(last_o1), 32'(i == 3));
      check_eq($sformatf("t4_msb_grant%0d", i), 32'(grant_o1), 32'(i == 3));
      check_eq($sformatf("t4_lsb_data%0d", i), 32'(data_o0), 32'(8'(w >> (8 * i))));
      tick();
    end
    #1;
    check_eq("t4_msb_valid_done", 32'(valid_o1), 32'd0);

    // Clear on chunk 2; the queued word must not be popped during the clear.
    w  = 32'hCAFEBABE;
    w2 = 32'h87654321;
    push      = 1'b1;
    push_data = w;
    tick();
    push_data = w2;
    tick();
    push = 1'b0;
    tick();
    tick();
    clear_i = 1'b1;
    p0      = pops;
    #1;
    check_eq("t5_clr_valid", 32'(valid_o0), 32'd0);
    check_eq("t5_clr_grant", 32'(grant_o0), 32'd0);
    tick();
    clear_i = 1'b0;
    #1;
    exp_out("t5_idle", 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("t5_clr_pops", 32'(pops - p0), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_out($sformatf("t5_c%0d", i), 8'(w2 >> (8 * i)), 1'b1, i == 3, i == 3);
      tick();
    end
    #1;
    exp_out("t5_done", 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset mid-word with a second word waiting in the FIFO.
    push_word(32'hDDCCBBAA);
    push      = 1'b1;
    push_data = 32'h99887766;
    tick();
    push = 1'b0;
    tick();
    #1;
    check_eq("t6_pre_data", 32'(data_o0), 32'hBB);
    rst_n = 1'b0;
    #1;
    exp_out("t6_rst", 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check_eq($sformatf("t6_quiet%0d", i), 32'(valid_o0), 32'd0);
    end
    w = 32'h5A6B7C8D;
    push_word(w);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_out($sformatf("t6_c%0d", i), 8'(w >> (8 * i)), 1'b1, i == 3, i == 3);
      tick();
    end
    #1;
    exp_out("t6_done", 8'h00, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Sits directly downstream of the team's valid/grant generic FIFO.
- Pops one wide word from the FIFO pop side and emits it as RATIO = IN_WIDTH/OUT_WIDTH narrow chunks on a valid/grant output stream.
- Flags the final chunk of each word with last_o.
- Typical use: 32-bit FIFO feeding an 8-bit peripheral TX path (UART/SPI byte stream).

Parameters:
- IN_WIDTH, 32, width of the word popped from the FIFO.
- OUT_WIDTH, 8, width of one output chunk. IN_WIDTH mod OUT_WIDTH must be 0 and RATIO must be >= 2; a simulation-only initial check prints an error otherwise.
- MSB_FIRST, 0, chunk order: 0 sends bits [OUT_WIDTH-1:0] first, 1 sends the top chunk first.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush: drops the held word and returns to IDLE.
- data_i  in  IN_WIDTH  word from FIFO data_o.
- valid_i  in  1  from FIFO valid_o.
- grant_o  out  1  to FIFO grant_i (pop).
- data_o  out  OUT_WIDTH  current chunk.
- valid_o  out  1  chunk valid.
- last_o  out  1  current chunk is the final chunk of its word.
- grant_i  in  1  consumer accepts chunk.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous, active-low: clock clk, reset rst_n (active-low).
- Reset values: state = IDLE, held word = 0, chunk counter = 0. Outputs: valid_o=0, last_o=0, data_o=0, grant_o=1.
- Counter: CNT_W = max(1, $clog2(RATIO)) bits. Counts 0..RATIO-1; no wrap beyond RATIO-1. Compare against RATIO-1 explicitly; never rely on power-of-2 overflow.
- Chunk select: chunk k = word[k*OUT_WIDTH +: OUT_WIDTH], where k = cnt if MSB_FIRST=0, else RATIO-1-cnt.
- Word accept: occurs when valid_i && grant_o. The word is registered, cnt is set to 0, and the block enters BUSY.
- States:
  - IDLE: grant_o=1, valid_o=0, data_o=0, last_o=0. Accept -> BUSY.
  - BUSY: valid_o=1, data_o=chunk(cnt), last_o=(cnt==RATIO-1).
    - grant_i=1 and not last: cnt+1, stay in BUSY.
    - grant_i=0: hold all state; data_o, valid_o and last_o stay stable.
    - grant_i=1 and last: grant_o=1 this cycle (combinational grant_i -> grant_o path, permitted because the FIFO drives valid_o from registered state only).
      - valid_i=1: the next word is accepted in the same edge, cnt=0, stay in BUSY. This gives zero bubbles.
      - valid_i=0: go to IDLE.
  - grant_o=0 in BUSY whenever the last chunk is not being granted.
- Latency: a word accepted at edge N presents chunk 0 in the cycle after edge N. Sustained throughput is 1 chunk/cycle; RATIO cycles per word with no bubbles.
- clear_i:
  - Has priority over all transitions.
  - Forces grant_o=0 and valid_o=0 in the cycle it is high, so no pop and no chunk transfer occur.
  - Next state is IDLE with cnt=0. The held word is not required to be zeroed.
- Reset mid-word: the partial word is lost and the outputs return to reset values immediately (asynchronously).
- Protocol rules:
  - No data_i sampling when grant_o=0.
  - valid_o never drops without a grant of the last chunk or a clear.
  - The unused state encoding recovers to IDLE.
- Assertions (sim only): data_o/last_o stable while valid_o && !grant_i; at most RATIO grants per accepted word.

Decomposition:
- Package ser_pkg: state enum ser_state_e {IDLE, BUSY} (logic [0:0]) and a width-check function ser_ratio(IN,OUT).
- No sub-module: a single FSM plus a word register and a counter, roughly 150-200 lines.
- Benches instantiate it behind generic_fifo (DATA_WIDTH=IN_WIDTH).

Test Plan:
- Reset, then push 0xDDCCBBAA with grant_i=1 always -> data_o = AA, BB, CC, DD on 4 consecutive cycles; last_o only on DD; valid_o falls the next cycle; exactly one FIFO pop.
- Two words back-to-back, 0x04030201 then 0x08070605, grant_i=1 -> 8 consecutive chunks 01..08 with no bubble; grant_o high only on the cycles carrying chunks 04 and (IDLE) accept.
- Backpressure: grant_i low for 3 cycles while on chunk BB -> data_o=BB, valid_o=1, last_o=0 held stable; resumes with CC; no FIFO pop during the stall.
- MSB_FIRST=1, word 0x11223344 -> chunk order 11, 22, 33, 44; last_o on 44.
- clear_i pulse while on chunk 2 of 0xCAFEBABE -> valid_o=0 the following cycle, FIFO not popped in the clear cycle; the next FIFO word starts cleanly at chunk 0.
- Reset asserted mid-word (chunk 1) -> valid_o=0 and grant_o=1 immediately; after release the FIFO contents (also reset) produce no output; a new push serializes correctly.
